uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the oversampling UART receiver. It takes each completed byte from the receiver's data/done outputs and pushes it into a first-word-fall-through FIFO. Bytes leave through a valid/ready stream interface. It also keeps a sticky overflow flag and a saturating count of receiver error events, both cleared by software.

---
 rtl/uart_rx_fifo.sv | 97 +++++++++
 tb/tb_uart_rx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: edge-detected byte capture into a FWFT FIFO,
// with a sticky overflow flag and a saturating receiver-error counter.
module uart_rx_fifo #(
  parameter int Depth         = 8,
  parameter int ErrCountWidth = 8
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic [7:0]                 rxData,
  input  logic                       rxDone,
  input  logic                       rxErr,
  output logic [7:0]                 outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(Depth):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [ErrCountWidth-1:0]   errCount,
  input  logic                       clearFlags
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] readPtr;
  logic [PtrW-1:0] writePtr;
  logic            doneQ;
  logic            doneQ2;
  logic            errQ;
  logic            push;
  logic            pop;
  logic            accept;
  logic            drop;
  logic            errEvent;

  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign outValid = !empty;
  assign outData  = empty ? 8'h00 : mem[readPtr];

  // rxData settles one clk after rxDone rises, so capture on the delayed edge
  assign push     = doneQ && !doneQ2;
  assign pop      = outValid && outReady;
  assign accept   = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign errEvent = rxErr && !errQ;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      doneQ  <= 1'b0;
      doneQ2 <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      doneQ  <= rxDone;
      doneQ2 <= doneQ;
      errQ   <= rxErr;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[writePtr] <= rxData;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else begin
      if (accept) writePtr <= writePtr + 1'b1;
      if (pop)    readPtr  <= readPtr + 1'b1;
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // new events take priority over a software clear in the same cycle
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (drop)            overflow <= 1'b1;
      else if (clearFlags) overflow <= 1'b0;
      if (clearFlags)
        errCount <= errEvent ? ErrCountWidth'(1) : '0;
      else if (errEvent && errCount != '1)
        errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for fill/overflow,
// hand sequences for latency, wrap, error counter and async reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic       outReady;
  logic       clearFlags;
  logic [7:0] outData;
  logic       outValid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] errCount;

  logic [7:0] outData2;
  logic       outValid2;
  logic [3:0] count2;
  logic       full2;
  logic       empty2;
  logic       overflow2;
  logic [1:0] errCount2;

  int passCnt = 0;
  int total   = 0;

  uart_rx_fifo #(.Depth(8), .ErrCountWidth(8)) dut (
    .clk(clk), .nReset(nReset),
    .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
    .outData(outData), .outValid(outValid),
    .outReady(outReady), .count(count),
    .full(full), .empty(empty),
    .overflow(overflow), .errCount(errCount),
    .clearFlags(clearFlags)
  );

  uart_rx_fifo #(.Depth(8), .ErrCountWidth(2)) dut2 (
    .clk(clk), .nReset(nReset),
    .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
    .outData(outData2), .outValid(outValid2),
    .outReady(outReady), .count(count2),
    .full(full2), .empty(empty2),
    .overflow(overflow2), .errCount(errCount2),
    .clearFlags(clearFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] expCount;
    logic       expFull;
    logic       expOvf;
  } vec_t;

  vec_t vecs [9];

  bit         mon = 1'b0;
  int         maxCnt = 0;
  logic [7:0] got [$];
  logic [7:0] sent [$];

  always @(posedge clk) begin
    if (mon) begin
      if (outValid && outReady) got.push_back(outData);
      if (int'(count) > maxCnt) maxCnt = int'(count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic sendByte(logic [7:0] b, int hold);
    rxData = b;
    rxDone = 1'b1;
    repeat (hold) step();
    rxDone = 1'b0;
    repeat (2) step();
  endtask

  task automatic popOne();
    outReady = 1'b1;
    step();
    outReady = 1'b0;
  endtask

  task automatic errPulse(int len);
    rxErr = 1'b1;
    repeat (len) step();
    rxErr = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{8'h00, 4'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 4'd2, 1'b0, 1'b0};
    vecs[2] = '{8'h02, 4'd3, 1'b0, 1'b0};
    vecs[3] = '{8'h03, 4'd4, 1'b0, 1'b0};
    vecs[4] = '{8'h04, 4'd5, 1'b0, 1'b0};
    vecs[5] = '{8'h05, 4'd6, 1'b0, 1'b0};
    vecs[6] = '{8'h06, 4'd7, 1'b0, 1'b0};
    vecs[7] = '{8'h07, 4'd8, 1'b1, 1'b0};
    vecs[8] = '{8'h08, 4'd8, 1'b1, 1'b1};

    nReset = 1'b0;
    rxData = 8'h00;
    rxDone = 1'b0;
    rxErr = 1'b0;
    outReady = 1'b0;
    clearFlags = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", errCount, 0);
    #10;
    nReset = 1'b1;
    step();

    // single byte, rxDone held 4 clks
    rxData = 8'hA5;
    rxDone = 1'b1;
    step();
    check("t1_lat1_count", count, 0);
    step();
    check("t1_valid", outValid, 1);
    check("t1_data", outData, 8'hA5);
    repeat (2) step();
    rxDone = 1'b0;
    repeat (2) step();
    check("t1_onepush", count, 1);
    popOne();
    check("t1_pop_count", count, 0);
    check("t1_pop_empty", empty, 1);
    check("t1_pop_data", outData, 0);

    // fill and overflow from the vector table
    foreach (vecs[i]) begin
      sendByte(vecs[i].data, 1);
      check($sformatf("t2_count%0d", i), count,
            vecs[i].expCount);
      check($sformatf("t2_full%0d", i), full,
            vecs[i].expFull);
      check($sformatf("t2_ovf%0d", i), overflow,
            vecs[i].expOvf);
      check($sformatf("t2_head%0d", i), outData, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_drain%0d", i), outData, i);
      popOne();
    end
    check("t2_empty", empty, 1);
    check("t2_ovf_sticky", overflow, 1);

    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    check("t3_clr_ovf", overflow, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) sendByte(8'(8'h10 + i), 2);
    check("t3_full", full, 1);
    rxData = 8'h55;
    rxDone = 1'b1;
    step();
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    rxDone = 1'b0;
    check("t3_count", count, 8);
    check("t3_ovf", overflow, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t3_drain%0d", i), outData,
            8'(8'h11 + i));
      popOne();
    end
    check("t3_drain_last", outData, 8'h55);
    popOne();
    check("t3_empty", empty, 1);

    // wrap-around with continuous draining
    outReady = 1'b1;
    mon = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = 8'(i * 37 + 5);
      sent.push_back(v);
      sendByte(v, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();
    mon = 1'b0;
    outReady = 1'b0;
    check("t4_size", got.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < got.size())
        check($sformatf("t4_out%0d", i), got[i], sent[i]);
    end
    check("t4_maxcnt", maxCnt, 1);
    check("t4_empty", empty, 1);

    // error counter and saturation
    errPulse(1);
    errPulse(2);
    errPulse(5);
    check("t5_err3", errCount, 3);
    check("t5_sat3", errCount2, 3);
    errPulse(1);
    errPulse(1);
    check("t5_err5", errCount, 5);
    check("t5_sat5", errCount2, 3);
    check("t5_nofifo", count, 0);
    clearFlags = 1'b1;
    rxErr = 1'b1;
    step();
    clearFlags = 1'b0;
    rxErr = 1'b0;
    step();
    check("t5_clr_err", errCount, 1);
    check("t5_clr_err2", errCount2, 1);

    // drop coinciding with clear keeps overflow set
    for (int i = 0; i < 8; i++) sendByte(8'(8'h20 + i), 1);
    rxData = 8'h99;
    rxDone = 1'b1;
    step();
    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    rxDone = 1'b0;
    check("t6_ovf_win", overflow, 1);
    check("t6_cnt8", count, 8);
    step();
    repeat (3) popOne();
    check("t6_cnt5", count, 5);
    check("t6_head", outData, 8'h23);

    // asynchronous reset mid-cycle
    #3;
    nReset = 1'b0;
    #1;
    check("t6_ar_count", count, 0);
    check("t6_ar_empty", empty, 1);
    check("t6_ar_valid", outValid, 0);
    check("t6_ar_ovf", overflow, 0);
    check("t6_ar_err", errCount, 0);
    check("t6_ar_data", outData, 0);

    // rxDone held through reset release counts as a rising edge
    rxData = 8'h3C;
    rxDone = 1'b1;
    step();
    nReset = 1'b1;
    repeat (2) step();
    check("t6_held_push", count, 1);
    check("t6_held_data", outData, 8'h3C);
    repeat (3) step();
    rxDone = 1'b0;
    repeat (2) step();
    check("t6_held_once", count, 1);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
